// File: rtl/data_mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface data_mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store engine: checks the access, runs one req/ack transaction
// on the data-memory bus, places store lanes and extends load data.
//
// state | meaning
// IDLE  | waiting for a load/store; illegal requests pulse err and stay here
// REQ   | mem_req held, waiting for mem_ack or the wait-counter timeout
// DONE  | one cycle with busy low so the pipeline advances; inputs ignored
module data_mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [2:0]                    func3,
    input  logic [31:0]                   address,
    input  logic [31:0]                   write_data,
    output logic [31:0]                   read_data,
    output logic                          busy,
    output logic                          err,
    data_mem_access_unit_if.master        mem
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          req_q;
    logic          we_q;
    logic [29:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

    logic          legal_f3;
    logic          aligned;
    logic          req_valid;
    logic          req_bad;
    logic [3:0]    be_wr;
    logic [31:0]   wd_lane;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_ext;

    always_comb begin
        if (mem_write)
            legal_f3 = !func3[2] && (func3[1:0] != 2'b11);
        else
            legal_f3 = (func3[1:0] != 2'b11) && (func3 != 3'b110);

        case (func3[1:0])
            2'b01:   aligned = !address[0];
            2'b10:   aligned = (address[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        req_valid = (mem_read ^ mem_write) && legal_f3 && aligned;
        req_bad   = (mem_read | mem_write) && !req_valid;

        case (func3[1:0])
            2'b00: begin
                be_wr   = 4'b0001 << address[1:0];
                wd_lane = {4{write_data[7:0]}};
            end
            2'b01: begin
                be_wr   = 4'b0011 << address[1:0];
                wd_lane = {2{write_data[15:0]}};
            end
            default: begin
                be_wr   = 4'b1111;
                wd_lane = write_data;
            end
        endcase
    end

    // Load extraction uses the size/offset captured at accept time, not the live inputs.
    always_comb begin
        byte_v = mem.mem_rdata[{off_q, 3'b000} +: 8];
        half_v = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'h0, byte_v};
            3'b101:  load_ext = {16'h0, half_v};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // Gated by rst_n so the stall drops the moment reset asserts.
    assign busy = rst_n && ((state == REQ) || ((state == IDLE) && req_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 30'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            read_data <= 32'h0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state   <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= address[31:2];
                        be_q    <= mem_write ? be_wr : 4'b1111;
                        wdata_q <= wd_lane;
                        f3_q    <= func3;
                        off_q   <= address[1:0];
                        cnt     <= '0;
                    end else begin
                        err <= req_bad;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        state <= DONE;
                        if (!we_q)
                            read_data <= load_ext;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        req_q     <= 1'b0;
                        read_data <= 32'h0;
                        err       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req     = req_q;
    assign mem.mem_we      = we_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_byte_en = be_q;
    assign mem.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed vector table, randomized traffic
// against a behavioural model, timeout and asynchronous-reset sequences.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rd = 1'b0, wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = 32'h0, wd = 32'h0;
    logic [31:0] rdata_o;
    logic        busy, err;
    data_mem_access_unit_if bus();

    logic        t_rd = 1'b0, t_wr = 1'b0;
    logic [2:0]  t_f3 = 3'b000;
    logic [31:0] t_addr = 32'h0, t_wd = 32'h0;
    logic [31:0] t_rdata_o;
    logic        t_busy, t_err;
    data_mem_access_unit_if t_bus();

    always #5 clk = ~clk;

    data_mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .func3(f3),
        .address(addr), .write_data(wd), .read_data(rdata_o), .busy(busy),
        .err(err), .mem(bus.master)
    );

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .mem_read(t_rd), .mem_write(t_wr), .func3(t_f3),
        .address(t_addr), .write_data(t_wd), .read_data(t_rdata_o), .busy(t_busy),
        .err(t_err), .mem(t_bus.master)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Behavioural model: access size in bytes, legality, lanes and extension.
    function automatic int m_size(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic logic m_err(input logic r, input logic w, input logic [2:0] f,
                                   input logic [31:0] a);
        if (!r && !w) return 1'b0;
        if (r && w) return 1'b1;
        if (f[1:0] == 2'b11 || f == 3'b110) return 1'b1;
        if (w && f[2]) return 1'b1;
        return (a % m_size(f)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic w, input logic [2:0] f, input logic [31:0] a);
        int m;
        if (!w) return 4'hF;
        m = ((1 << m_size(f)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        case (m_size(f))
            1:       return 32'(d & 32'hFF) * 32'h0101_0101;
            2:       return 32'(d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] rdv);
        logic [31:0] v;
        int sz;
        sz = m_size(f);
        v  = rdv >> (8 * (a % 4));
        if (sz == 1) v = v & 32'hFF;
        if (sz == 2) v = v & 32'hFFFF;
        if (!f[2] && sz == 1 && v >= 32'd128)   v = v - 32'd256;
        if (!f[2] && sz == 2 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic run_txn(input string tag, input logic r, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdv,
                           input int wt, input logic x_err, input logic [29:0] x_addr,
                           input logic [3:0] x_be, input logic [31:0] x_wdata,
                           input logic [31:0] x_rdata);
        logic valid;
        logic req_ok;
        int   bcnt;
        valid = (r ^ w) && !x_err;
        @(negedge clk);
        rd = r; wr = w; f3 = f; addr = a; wd = d; bus.mem_ack = 1'b0;
        #1;
        chk1({tag, " busy_accept"}, busy, valid);
        if (!valid) begin
            @(negedge clk);
            chk1({tag, " err"}, err, x_err);
            chk1({tag, " no_req"}, bus.mem_req, 1'b0);
            rd = 1'b0; wr = 1'b0;
            @(negedge clk);
            chk1({tag, " err_pulse"}, err, 1'b0);
            chk({tag, " rdata_hold"}, rdata_o, x_rdata);
        end else begin
            bcnt = 1;
            req_ok = 1'b1;
            for (int k = 1; k <= wt; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    chk({tag, " addr"}, 32'(bus.mem_addr), 32'(x_addr));
                    chk1({tag, " we"}, bus.mem_we, w);
                    chk({tag, " be"}, 32'(bus.mem_byte_en), 32'(x_be));
                    if (w) chk({tag, " wdata"}, bus.mem_wdata, x_wdata);
                end
                if (bus.mem_req !== 1'b1) req_ok = 1'b0;
                if (k == wt) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rdv;
                end
                #1;
                if (busy) bcnt++;
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            chk({tag, " busy_cycles"}, bcnt, wt + 1);
            chk1({tag, " req_held"}, req_ok, 1'b1);
            chk1({tag, " done_busy"}, busy, 1'b0);
            chk1({tag, " done_req"}, bus.mem_req, 1'b0);
            chk({tag, " rdata"}, rdata_o, x_rdata);
            chk1({tag, " done_err"}, err, 1'b0);
            bus.mem_ack = 1'b1;
            bus.mem_rdata = ~rdv;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            rd = 1'b0; wr = 1'b0;
            #1;
            chk({tag, " ack_ignored"}, rdata_o, x_rdata);
            chk1({tag, " idle_req"}, bus.mem_req, 1'b0);
        end
    endtask

    typedef struct {
        logic        r, w;
        logic [2:0]  f;
        logic [31:0] a, d, rdv;
        int          wt;
        logic        x_err;
        logic [29:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata, x_rdata;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] hold, ra, rdv_r, d_r;
        logic        r_r, w_r, e_r;
        logic [2:0]  f_r;
        int          sel, rcnt;
        logic        seen_end;

        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0, 30'h40, 4'hF, 32'h0, 32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 30'h81, 4'hC, 32'hBEEF_BEEF, 32'hFFFF_FF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 5, 1'b0, 30'h4, 4'hF, 32'h0, 32'h1234_5678};
        tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1'b1, 30'h0, 4'h0, 32'h0, 32'h1234_5678};
        tbl[4]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF_9234, 1, 1'b0, 30'h40, 4'hF, 32'h0, 32'hFFFF_FF92};
        tbl[5]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h80FF_9234, 3, 1'b0, 30'h40, 4'hF, 32'h0, 32'h0000_0092};
        tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 1, 1'b0, 30'h40, 4'hF, 32'h0, 32'hFFFF_80FF};
        tbl[7]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 2, 1'b0, 30'h40, 4'hF, 32'h0, 32'h0000_80FF};
        tbl[8]  = '{1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 1, 1'b0, 30'h0, 4'h2, 32'hA5A5_A5A5, 32'h0000_80FF};
        tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h008, 32'h1122_3344, 32'h0, 1, 1'b0, 30'h2, 4'hF, 32'h1122_3344, 32'h0000_80FF};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0000_80FF};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0000_80FF};
        tbl[12] = '{1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 1, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0000_80FF};
        tbl[13] = '{1'b0, 1'b1, 3'b001, 32'h3, 32'h0, 32'h0, 1, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0000_80FF};
        tbl[14] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1, 1'b0, 30'h0, 4'h0, 32'h0, 32'h0000_80FF};
        tbl[15] = '{1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h5555_7FFF, 1, 1'b0, 30'h0, 4'hF, 32'h0, 32'h0000_7FFF};
        tbl[16] = '{1'b0, 1'b1, 3'b000, 32'h7, 32'h1234_5666, 32'h0, 2, 1'b0, 30'h1, 4'h8, 32'h6666_6666, 32'h0000_7FFF};

        bus.mem_ack = 1'b0;   bus.mem_rdata = 32'h0;
        t_bus.mem_ack = 1'b0; t_bus.mem_rdata = 32'h0;

        #2;
        chk("rst read_data", rdata_o, 32'h0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst err", err, 1'b0);
        chk1("rst mem_req", bus.mem_req, 1'b0);
        chk1("rst mem_we", bus.mem_we, 1'b0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst byte_en", 32'(bus.mem_byte_en), 32'h0);
        chk("rst wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            run_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d,
                    tbl[i].rdv, tbl[i].wt, tbl[i].x_err, tbl[i].x_addr, tbl[i].x_be,
                    tbl[i].x_wdata, tbl[i].x_rdata);

        hold = 32'h0000_7FFF;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            r_r = (sel == 1) || (sel >= 2 && sel <= 5);
            w_r = (sel == 1) || (sel >= 6);
            f_r = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            d_r = $urandom;
            rdv_r = $urandom;
            e_r = m_err(r_r, w_r, f_r, ra);
            if (!e_r && r_r && !w_r) hold = m_load(f_r, ra, rdv_r);
            run_txn($sformatf("rnd%0d", i), r_r, w_r, f_r, ra, d_r, rdv_r,
                    $urandom_range(1, 4), e_r, ra[31:2], m_be(w_r, f_r, ra),
                    m_wdata(f_r, d_r), hold);
        end

        // Load with no ack on the short-timeout instance, preceded by a good load.
        @(negedge clk);
        t_rd = 1'b1; t_f3 = 3'b010; t_addr = 32'h20;
        @(negedge clk);
        t_bus.mem_ack = 1'b1; t_bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        t_bus.mem_ack = 1'b0; t_rd = 1'b0;
        chk("t load_ok", t_rdata_o, 32'hCAFE_F00D);
        @(negedge clk);
        t_rd = 1'b1; t_addr = 32'h24;
        rcnt = 0;
        seen_end = 1'b0;
        for (int i = 0; i < 20 && !seen_end; i++) begin
            @(negedge clk);
            if (t_bus.mem_req) rcnt++;
            else begin
                seen_end = 1'b1;
                chk1("t timeout err", t_err, 1'b1);
                chk("t timeout rdata", t_rdata_o, 32'h0);
                chk1("t timeout busy", t_busy, 1'b0);
            end
        end
        chk1("t timeout seen", seen_end, 1'b1);
        chk("t req_cycles", rcnt, 4);
        t_rd = 1'b0;
        @(negedge clk);
        chk1("t err_pulse", t_err, 1'b0);
        chk1("t idle_req", t_bus.mem_req, 1'b0);

        // Asynchronous reset while a load is outstanding.
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h40; bus.mem_ack = 1'b0;
        @(negedge clk);
        chk1("mid req", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst mem_req", bus.mem_req, 1'b0);
        chk1("arst busy", busy, 1'b0);
        chk("arst read_data", rdata_o, 32'h0);
        chk("arst byte_en", 32'(bus.mem_byte_en), 32'h0);
        chk("arst mem_addr", 32'(bus.mem_addr), 32'h0);
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h0000_0AB0, 32'h55AA_33CC, 32'h0, 2,
                1'b0, 30'h2AC, 4'hF, 32'h55AA_33CC, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
